// File: rtl/alu_result_monitor.sv
// alu_result_monitor: response-side companion for the 16-bit ALU.
// Samples W/neg/zer over a run of N_SAMPLES steps, folds every sample into a
// 16-bit MISR signature (x^16+x^15+x^13+x^4+1) and checks the status flags
// against the result word on each sample.
// Optional feature macro: ALU_MON_FLAG_CHECK_EN. When it is defined, the flag
// check drives err/err_count/err_opc. When it is undefined, those outputs are
// tied to 0 and the check logic is not built.
module alu_result_monitor #(
  parameter int          N_SAMPLES = 8,
  parameter logic [15:0] SEED      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sample,
  input  logic [15:0] W,
  input  logic        neg,
  input  logic        zer,
  input  logic [2:0]  opc,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature,
  output logic        err,
  output logic [3:0]  err_count,
  output logic [2:0]  err_opc
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter value on the final sampling edge of a run.
  localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] sig_q, sig_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        run_start;
  logic        sample_take;
  logic [15:0] misr_word;
  logic        misr_fb;

  // A start is only honoured in IDLE; a sample only counts in RUN.
  assign run_start   = (state_q == S_IDLE) && start;
  assign sample_take = (state_q == S_RUN) && sample;

  // The flags ride in the two low bits of the word folded into the MISR.
  assign misr_word = W ^ {14'b0, neg, zer};
  assign misr_fb   = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];

  // Next-state logic for the FSM, the sample counter and the MISR.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          sig_d   = SEED;
          cnt_d   = 8'd0;
        end
      end
      S_RUN: begin
        if (sample) begin
          sig_d = {sig_q[14:0], misr_fb} ^ misr_word;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the state being entered.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State registers; synchronous reset has priority over everything else.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sig_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;

`ifdef ALU_MON_FLAG_CHECK_EN
  logic       err_q, err_d;
  logic [3:0] err_count_q, err_count_d;
  logic [2:0] err_opc_q, err_opc_d;
  logic       flag_bad;

  // neg must mirror the sign bit and zer must mirror an all-zero word.
  assign flag_bad = (neg != W[15]) || (zer != (W == 16'h0000));

  // Error bookkeeping: cleared on an accepted start, updated on bad samples.
  always_comb begin
    err_d       = err_q;
    err_count_d = err_count_q;
    err_opc_d   = err_opc_q;

    if (run_start) begin
      err_d       = 1'b0;
      err_count_d = 4'd0;
      err_opc_d   = 3'd0;
    end else if (sample_take && flag_bad) begin
      err_d = 1'b1;
      if (err_count_q != 4'hF) begin
        err_count_d = err_count_q + 4'd1;
      end
      // Only the first mismatch of a run records its opcode.
      if (!err_q) begin
        err_opc_d = opc;
      end
    end
  end

  // Error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_count_q <= 4'd0;
      err_opc_q   <= 3'd0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
      err_opc_q   <= err_opc_d;
    end
  end

  assign err       = err_q;
  assign err_count = err_count_q;
  assign err_opc   = err_opc_q;
`else
  // Without the flag check the opcode has no consumer.
  logic unused_opc;
  assign unused_opc = ^opc;

  assign err       = 1'b0;
  assign err_count = 4'd0;
  assign err_opc   = 3'd0;
`endif

endmodule

// File: tb/tb_alu_result_monitor.sv
// Testbench for alu_result_monitor. Three instances with N_SAMPLES 1, 8 and
// 20 share the data inputs and have their own start/sample strobes. Only one
// instance runs at a time. A reference model computes the expected MISR and
// error state with plain arithmetic. Each end-of-run expectation is queued
// when the final sample is issued, and a monitor compares it when done pulses.
module tb_alu_result_monitor;

`ifdef ALU_MON_FLAG_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [15:0] SEED0 = 16'hFFFF;
  localparam logic [15:0] SEED1 = 16'hFFFF;
  localparam logic [15:0] SEED2 = 16'h1234;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  start_r, sample_r;
  logic [15:0] w_r;
  logic        neg_r, zer_r;
  logic [2:0]  opc_r;

  logic [2:0]  busy_w, done_w, err_w;
  logic [15:0] sig_w  [3];
  logic [3:0]  errc_w [3];
  logic [2:0]  erro_w [3];

  alu_result_monitor #(.N_SAMPLES(1), .SEED(SEED0)) dut0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .sample(sample_r[0]),
    .W(w_r), .neg(neg_r), .zer(zer_r), .opc(opc_r),
    .busy(busy_w[0]), .done(done_w[0]), .signature(sig_w[0]),
    .err(err_w[0]), .err_count(errc_w[0]), .err_opc(erro_w[0])
  );

  alu_result_monitor #(.N_SAMPLES(8), .SEED(SEED1)) dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .sample(sample_r[1]),
    .W(w_r), .neg(neg_r), .zer(zer_r), .opc(opc_r),
    .busy(busy_w[1]), .done(done_w[1]), .signature(sig_w[1]),
    .err(err_w[1]), .err_count(errc_w[1]), .err_opc(erro_w[1])
  );

  alu_result_monitor #(.N_SAMPLES(20), .SEED(SEED2)) dut2 (
    .clk(clk), .rst(rst), .start(start_r[2]), .sample(sample_r[2]),
    .W(w_r), .neg(neg_r), .zer(zer_r), .opc(opc_r),
    .busy(busy_w[2]), .done(done_w[2]), .signature(sig_w[2]),
    .err(err_w[2]), .err_count(errc_w[2]), .err_opc(erro_w[2])
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          k;
    logic [15:0] sig;
    logic        err;
    logic [3:0]  cnt;
    logic [2:0]  opc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state for the run in progress.
  logic [15:0] m_sig;
  int          m_errs;
  bit          m_err;
  logic [2:0]  m_opc;
  logic [15:0] held_sig [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] seed_of(input int k);
    case (k)
      0:       return SEED0;
      1:       return SEED1;
      default: return SEED2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever an instance pulses done, pop and compare its expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (done_w[k] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut=%0d actual=1 expected=0", k);
        end else begin
          e = exp_q.pop_front();
          check("done_dut", k, e.k);
          check("final_sig", sig_w[k], e.sig);
          check("final_err", err_w[k], e.err);
          check("final_err_count", errc_w[k], e.cnt);
          check("final_err_opc", erro_w[k], e.opc);
          check("busy_in_done", busy_w[k], 0);
        end
      end
    end
  end

  task automatic start_run(input int k);
    start_r[k] = 1'b1;
    tick();
    start_r[k] = 1'b0;
    m_sig  = seed_of(k);
    m_errs = 0;
    m_err  = 1'b0;
    m_opc  = 3'd0;
    check("busy_rise", busy_w[k], 1);
    check("seed_load", sig_w[k], m_sig);
    check("err_clear", {err_w[k], errc_w[k], erro_w[k]}, 0);
  endtask

  // Issue one sample; the model result is computed before the edge.
  task automatic apply(input int k, input logic [15:0] w, input logic n, input logic z,
                       input logic [2:0] o, input bit last);
    logic [15:0] d;
    logic        fb;
    bit          bad;
    exp_t        e;
    d     = w ^ {14'b0, n, z};
    fb    = ^(m_sig & 16'hD008);
    m_sig = (m_sig << 1) ^ {15'b0, fb} ^ d;
    bad   = (n != (w >= 16'h8000)) || (z != (w == 16'h0000));
    if (CHK_EN && bad) begin
      if (!m_err) m_opc = o;
      m_err = 1'b1;
      if (m_errs < 15) m_errs++;
    end
    if (last) begin
      e.k   = k;
      e.sig = m_sig;
      e.err = m_err;
      e.cnt = 4'(m_errs);
      e.opc = m_opc;
      exp_q.push_back(e);
    end
    held_sig[k] = m_sig;
    w_r = w; neg_r = n; zer_r = z; opc_r = o;
    sample_r[k] = 1'b1;
    tick();
    sample_r[k] = 1'b0;
    check("sig_step", sig_w[k], m_sig);
    check("errc_step", errc_w[k], m_errs);
    check("busy_step", busy_w[k], !last);
    check("done_step", done_w[k], last);
  endtask

  task automatic rand_apply(input int k, input int bad_pct, input bit last);
    logic [15:0] w;
    logic        n, z;
    w = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
    n = w[15];
    z = (w == 16'h0000);
    if (int'($urandom_range(0, 99)) < bad_pct) begin
      if ($urandom_range(0, 1) == 1) n = ~n;
      else z = ~z;
    end
    apply(k, w, n, z, 3'($urandom_range(0, 7)), last);
  endtask

  // RUN cycles with sample low must leave everything untouched.
  task automatic gap(input int k, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      w_r = 16'($urandom);
      tick();
      check("gap_sig", sig_w[k], m_sig);
      check("gap_busy", busy_w[k], 1);
    end
  endtask

  // Leave DONE and confirm the held outputs in IDLE.
  task automatic finish_run(input int k);
    tick();
    check("done_single", done_w[k], 0);
    check("idle_busy", busy_w[k], 0);
    check("idle_sig_hold", sig_w[k], m_sig);
  endtask

  task automatic idle_sample(input int k);
    w_r = 16'($urandom); neg_r = 1'($urandom); zer_r = 1'($urandom);
    sample_r[k] = 1'b1;
    tick();
    sample_r[k] = 1'b0;
    check("idle_sample_sig", sig_w[k], held_sig[k]);
    check("idle_sample_busy", busy_w[k], 0);
  endtask

  task automatic rand_run(input int k, input int n, input int bad_pct);
    start_run(k);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) gap(k, int'($urandom_range(1, 2)));
      rand_apply(k, bad_pct, i == n - 1);
    end
    finish_run(k);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout pending=%0d", exp_q.size());
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    rst = 1'b1; start_r = '0; sample_r = '0;
    w_r = '0; neg_r = 1'b0; zer_r = 1'b0; opc_r = '0;
    for (int k = 0; k < 3; k++) held_sig[k] = 16'h0000;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_busy", busy_w[k], 0);
      check("rst_done", done_w[k], 0);
      check("rst_sig", sig_w[k], 16'h0000);
      check("rst_err", {err_w[k], errc_w[k], erro_w[k]}, 0);
    end
    rst = 1'b0;
    tick();

    // Single-sample runs with hand-computed signatures.
    start_run(0);
    apply(0, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b1);
    check("n1_zero_sig", sig_w[0], 16'hFFFF);
    finish_run(0);
    start_run(0);
    apply(0, 16'h8000, 1'b1, 1'b0, 3'd1, 1'b1);
    check("n1_neg_sig", sig_w[0], 16'h7FFC);
    finish_run(0);
    idle_sample(0);

    // Opcodes 0..7, one bad zero flag at opc 3, plus a start pulse mid-run.
    start_run(1);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        start_r[1] = 1'b1;
        tick();
        start_r[1] = 1'b0;
        check("start_in_run_busy", busy_w[1], 1);
        check("start_in_run_sig", sig_w[1], m_sig);
      end
      if (i == 3) begin
        apply(1, 16'h0005, 1'b0, 1'b1, 3'd3, 1'b0);
      end else begin
        w = 16'($urandom);
        apply(1, w, w[15], w == 16'h0000, 3'(i), i == 7);
      end
      if (i == 1) gap(1, 2);
    end
    check("opc3_err", err_w[1], CHK_EN);
    check("opc3_err_opc", erro_w[1], CHK_EN ? 3 : 0);
    finish_run(1);
    idle_sample(1);

    // Twenty bad samples saturate the count; start held through DONE chains a run.
    start_run(2);
    for (int i = 0; i < 20; i++) begin
      w = 16'($urandom);
      apply(2, w, ~w[15], w == 16'h0000, 3'($urandom_range(0, 7)), i == 19);
    end
    check("sat_count", errc_w[2], CHK_EN ? 15 : 0);
    start_r[2] = 1'b1;
    tick();
    check("chain_done_exit_busy", busy_w[2], 0);
    check("chain_done_exit_done", done_w[2], 0);
    tick();
    start_r[2] = 1'b0;
    check("chain_busy", busy_w[2], 1);
    check("chain_seed", sig_w[2], SEED2);
    m_sig = SEED2; m_errs = 0; m_err = 1'b0; m_opc = 3'd0;
    for (int i = 0; i < 20; i++) rand_apply(2, 20, i == 19);
    finish_run(2);

    // Reset after three samples aborts the run; a clean pass follows.
    start_run(1);
    for (int i = 0; i < 3; i++) rand_apply(1, 50, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) held_sig[k] = 16'h0000;
    check("midrst_busy", busy_w[1], 0);
    check("midrst_done", done_w[1], 0);
    check("midrst_sig", sig_w[1], 16'h0000);
    check("midrst_err", {err_w[1], errc_w[1], erro_w[1]}, 0);
    tick();
    check("midrst_idle", busy_w[1], 0);
    rand_run(1, 8, 0);
    check("clean_err", err_w[1], 0);

    // Randomized runs across all instances.
    for (int r = 0; r < 6; r++) begin
      rand_run(1, 8, 25);
      rand_run(0, 1, 50);
    end
    rand_run(2, 20, 30);
    idle_sample(2);

    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_monitor.md
# alu_result_monitor

Response-side companion to the 16-bit structural ALU. It samples the ALU's result word and status flags (`W`, `neg`, `zer`) over a run of opcode steps and checks flag consistency on every sample. It compresses all samples into a 16-bit MISR signature, so a run can be judged by a single compare rather than per-cycle golden values. It sits on the ALU outputs, alongside whatever drives `A`/`B`/`c`/`opc`.

## Interface
Parameters:
- `N_SAMPLES`, default 8: samples per run (1..255); 8 covers one pass of every opcode.
- `SEED`, default 16'hFFFF: MISR value loaded on `start`.

Ports:
- `clk`  input  1  rising-edge clock; one clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begin a run; honoured only in IDLE.
- `sample`  input  1  current `W`/`neg`/`zer`/`opc` are valid this cycle.
- `W`  input  16  ALU result word.
- `neg`  input  1  ALU negative flag.
- `zer`  input  1  ALU zero flag.
- `opc`  input  3  opcode that produced `W`; used for error capture.
- `busy`  output  1  high while in RUN.
- `done`  output  1  single-cycle pulse in the DONE state.
- `signature`  output  16  MISR contents; held after the run.
- `err`  output  1  sticky flag-mismatch indicator for the current run.
- `err_count`  output  4  mismatches this run; saturates at 15.
- `err_opc`  output  3  `opc` of the first mismatch this run.

## Operation
- FSM with three states: IDLE, RUN, DONE.
- IDLE → RUN on `start`=1. On that edge: `signature`←`SEED`, sample counter←0, `err`/`err_count`/`err_opc`←0.
- RUN, on a cycle with `sample`=1:
  - Data word: `d = W ^ {14'b0, neg, zer}`.
  - Feedback: `fb = sig[15]^sig[14]^sig[12]^sig[3]` (polynomial x^16+x^15+x^13+x^4+1).
  - Update: `sig ← {sig[14:0], fb} ^ d`.
  - Counter increments.
- RUN, on a cycle with `sample`=0: no state change.
- RUN → DONE on the sampling edge where the counter equals `N_SAMPLES-1`.
- DONE → IDLE unconditionally after one cycle.
- `start` is ignored in RUN and DONE.
- Flag check on every RUN sample. Mismatch when `neg != W[15]` or `zer != (W == 16'h0000)`. On a mismatch:
  - `err`←1.
  - `err_count` increments, saturating at 15.
  - If this is the first mismatch of the run, `err_opc`←`opc`.
- `sample` in IDLE or DONE is ignored; no signature or error update.
- All outputs hold their values in IDLE until the next accepted `start`.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `signature`=16'h0000, `err`=0, `err_count`=0, `err_opc`=0; FSM in IDLE.
- `rst` wins over every other input. Reset mid-RUN aborts the run and clears everything to the reset values on that edge.
- `busy` rises on the clock edge that accepts `start`.
- `signature` and the error outputs reflect a sample on the edge where `sample`=1.
- `done`=1 for exactly the one cycle after the final sampling edge; `busy`=0 in that cycle.
- Minimum run length is `N_SAMPLES`+2 cycles from `start` to return to IDLE.
- A `start` held high through DONE starts a new run on the first IDLE cycle.

## Configuration
- Macro `ALU_MON_FLAG_CHECK_EN`.
- Defined: flag checking, `err`, `err_count` and `err_opc` operate as specified above.
- Undefined: the check logic is not compiled; `err`, `err_count` and `err_opc` are constant 0. The MISR, FSM and handshake are unchanged.

## Test plan
- `N_SAMPLES`=1, `SEED`=FFFF; `start`, then sample `W`=0000, `neg`=0, `zer`=1 → `signature`=FFFF, `done` pulses once, `err`=0.
- `N_SAMPLES`=1; sample `W`=8000, `neg`=1, `zer`=0 → `signature`=7FFC, `err`=0.
- Default `N_SAMPLES`; 8 samples with `opc` 0..7, where the sample at `opc`=3 has `W`=0005, `zer`=1 → `err`=1, `err_count`=1, `err_opc`=3, `done` one cycle after the 8th sample.
- 20 consecutive bad-flag samples with `N_SAMPLES`=20 → `err_count` saturates at 15; `err_opc` keeps the first opcode.
- Assert `rst` for one cycle after 3 of 8 samples → all outputs 0, FSM in IDLE; a new `start` runs a clean 8-sample pass.
- `start` pulsed during RUN, and `sample` pulsed in IDLE → neither affects the counter, `signature` or `busy`.
